// File: rtl/query_patch_loader.sv
// query_patch_loader: packs streamed query elements into patch words and writes them to the query memory
module query_patch_loader #(
    parameter int DATA_WIDTH = 11,
    parameter int PATCH_SIZE = 5,
    parameter int ADDR_WIDTH = 9,
    parameter int DEPTH      = 512
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [ADDR_WIDTH:0]              num_patches,
    input  logic                             in_valid,
    input  logic [DATA_WIDTH-1:0]            in_data,
    output logic                             in_ready,
    output logic                             csb0,
    output logic                             web0,
    output logic [ADDR_WIDTH-1:0]            addr0,
    output logic [DATA_WIDTH*PATCH_SIZE-1:0] wpatch0,
    output logic                             busy,
    output logic                             done,
    output logic [ADDR_WIDTH:0]              patch_count
);
    localparam int CW = ADDR_WIDTH + 1;
    localparam int EW = PATCH_SIZE > 1 ? $clog2(PATCH_SIZE) : 1;
    localparam int PW = DATA_WIDTH * PATCH_SIZE;

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   target_q, target_d;
    logic [CW-1:0]   count_q, count_d;
    logic [EW-1:0]   elem_q, elem_d;
    logic [PW-1:0]   patch_q, patch_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [PW-1:0]   wpatch_q, wpatch_d;
    logic            wr_d, csb_q, ready_q, busy_q, done_q;

    assign in_ready    = ready_q;
    assign csb0        = csb_q;
    assign web0        = csb_q;
    assign addr0       = addr_q;
    assign wpatch0     = wpatch_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign patch_count = count_q;

    // Next state, element assembly and write scheduling; count_q doubles as the write address
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        count_d  = count_q;
        elem_d   = elem_q;
        patch_d  = patch_q;
        addr_d   = addr_q;
        wpatch_d = wpatch_q;
        wr_d     = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                target_d = num_patches > CW'(DEPTH) ? CW'(DEPTH) : num_patches;
                count_d  = '0;
                elem_d   = '0;
                state_d  = num_patches == '0 ? DONE : LOAD;
            end
            LOAD: if (in_valid && ready_q) begin
                patch_d[int'(elem_q)*DATA_WIDTH +: DATA_WIDTH] = in_data;
                elem_d = elem_q + EW'(1);
                if (elem_q == EW'(PATCH_SIZE - 1)) begin
                    elem_d   = '0;
                    wr_d     = 1'b1;
                    addr_d   = count_q[ADDR_WIDTH-1:0];
                    wpatch_d = patch_d;
                    count_d  = count_q + CW'(1);
                    state_d  = (count_q + CW'(1)) == target_q ? FLUSH : LOAD;
                end
            end
            FLUSH: state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset drops any partial patch and a pending write
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            target_q <= '0;
            count_q  <= '0;
            elem_q   <= '0;
            patch_q  <= '0;
            addr_q   <= '0;
            wpatch_q <= '0;
            csb_q    <= 1'b1;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            count_q  <= count_d;
            elem_q   <= elem_d;
            patch_q  <= patch_d;
            addr_q   <= addr_d;
            wpatch_q <= wpatch_d;
            csb_q    <= ~wr_d;
            ready_q  <= state_d == LOAD;
            busy_q   <= state_d != IDLE;
            done_q   <= state_d == DONE;
        end
    end
endmodule

// File: doc/query_patch_loader.md
# query_patch_loader

Front-end stage of the query path. Accepts query-image pixels from the chip I/O one element per cycle over a valid/ready handshake and assembles each group of PATCH_SIZE elements into one packed patch word. Writes each patch into the query patch memory's read/write port at consecutive addresses starting at 0, and reports completion. Drives the memory's active-low chip-select and write-enable directly. The memory's read port is left to the downstream search logic.

## Interface
Parameters:
- DATA_WIDTH, 11, bits per patch element
- PATCH_SIZE, 5, elements per patch
- ADDR_WIDTH, 9, query memory address width
- DEPTH, 512, query memory depth in patches

Ports:
- clk  in  1  single clock; all state changes on its rising edge
- rst  in  1  synchronous reset, active-high
- start  in  1  one-cycle request to begin a load; honoured only in IDLE
- num_patches  in  ADDR_WIDTH+1  patches to load; sampled on accepted start; values > DEPTH are clamped to DEPTH
- in_valid  in  1  in_data holds a valid element
- in_data  in  DATA_WIDTH  query element
- in_ready  out  1  loader accepts an element this cycle
- csb0  out  1  memory chip select, active-low
- web0  out  1  memory write enable, active-low
- addr0  out  ADDR_WIDTH  memory write address
- wpatch0  out  DATA_WIDTH*PATCH_SIZE  packed patch write data
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle completion pulse
- patch_count  out  ADDR_WIDTH+1  patches written in the current or most recent load

## Operation
- States: IDLE, LOAD, FLUSH, DONE.
- IDLE:
  - start=1 with num_patches=0 -> DONE.
  - start=1 with nonzero num_patches -> LOAD. Clears patch_count, the element counter, and the address counter.
- LOAD:
  - in_ready=1.
  - An element is accepted on each edge where in_valid && in_ready.
  - Element j (0..PATCH_SIZE-1) of a patch is placed at bits [j*DATA_WIDTH +: DATA_WIDTH], so element 0 lands in the LSBs.
  - On acceptance of element PATCH_SIZE-1, the assembled patch is registered for writing and the element counter returns to 0.
  - If that patch is the last one (patch_count+1 == clamped num_patches), the state goes to FLUSH.
- FLUSH: in_ready=0; the final write is driven; next state is DONE.
- DONE: done=1 for exactly one cycle; next state is IDLE.
- Writes:
  - For every completed patch k (0-based), exactly one write cycle occurs with csb0=0, web0=0, addr0=k, wpatch0=patch.
  - patch_count increments on that write cycle.
  - In every other cycle csb0=1 and web0=1. addr0 and wpatch0 hold their last values.
- Address handling: addresses never wrap, because the clamp to DEPTH guarantees k ≤ DEPTH-1.
- start outside IDLE is ignored. in_valid outside LOAD is ignored, and no element is consumed.
- in_valid gaps within a patch are allowed; partial patch contents persist across gaps.
- patch_count holds its final value after DONE until the next accepted start.

## Timing
- All outputs are registered.
- Reset values: in_ready=0, csb0=1, web0=1, addr0=0, wpatch0=0, busy=0, done=0, patch_count=0, state=IDLE.
- Start: start accepted at edge S -> state LOAD and in_ready=1 in cycle S+1.
- Write latency: element PATCH_SIZE-1 accepted at edge N -> write cycle is cycle N+1, and the memory captures at edge N+2.
- Streaming: back-to-back streaming needs no stall, giving one patch per PATCH_SIZE cycles. A write cycle overlaps acceptance of the next patch's element 0.
- Completion: the last patch's final element is accepted at edge N -> FLUSH and the write in cycle N+1, done=1 in cycle N+2, IDLE in cycle N+3.
- busy is high from S+1 through the done cycle inclusive.
- Reset mid-load:
  - Any in-progress partial patch is discarded.
  - A write pending in the same cycle is suppressed (csb0=1 the next cycle).
  - No done pulse is produced.
- Simultaneous rst and start: rst wins.

## Test plan
- Reset: assert rst with in_valid=1 and start=1 for 3 cycles -> all outputs hold their reset values, and in_ready stays 0.
- Single patch: start with num_patches=1, then elements 1,2,3,4,5 on consecutive cycles.
  - Expect exactly one write: addr0=0, wpatch0={5,4,3,2,1} with element 1 in bits [10:0].
  - done pulses 2 cycles after the element 5 edge; patch_count=1.
- Streaming: num_patches=4, continuous valid, element value = 5*k+j.
  - Expect writes at addr 0..3 spaced 5 cycles apart.
  - Expect no in_ready deassertion before the final element, and patch_count=4.
- Gaps and zero count:
  - num_patches=2 with in_valid toggling every cycle -> same data as a gap-free run.
  - num_patches=0 -> done one cycle after IDLE->DONE with no writes (csb0 stays 1).
- Clamp: num_patches=600 with DEPTH=512 -> exactly 512 writes, last at addr 511, patch_count=512.
- Abort and ignore: rst after 3 elements of patch 2 -> no further writes and no done.
  - A fresh start with num_patches=1 then writes addr 0.
  - A start asserted during LOAD changes nothing.
